// File: rtl/start_gen_pkg.sv
// start_gen_pkg: FSM state type and width shared by start_pulse_gen.
package start_gen_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_FIRE    = 3'd1,
    S_CLEAR   = 3'd2,
    S_RUN     = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw push-button into the clk domain and only
// accepts a new level once it has held steady for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstb,
  input  logic btn_raw,
  output logic btn_clean
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [CNT_W-1:0]       cnt_q;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous button through the synchronizer chain.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Count how long the synchronized level has disagreed with the clean level
  // and adopt it once the disagreement has lasted the full debounce window.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q     <= '0;
      btn_clean <= 1'b0;
    end else if (btn_sync == btn_clean) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      btn_clean <= btn_sync;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/start_pulse_gen.sv
// start_pulse_gen: turns a debounced button press into one single-cycle start
// pulse and blocks re-triggering until the downstream stage raises done.
// Optional feature macro START_GEN_TIMEOUT_EN: when defined, the wait for done
// is bounded by TIMEOUT_CYCLES and a one-cycle timeout pulse is raised on expiry;
// when undefined the wait is unbounded and timeout is tied low.
module start_pulse_gen
  import start_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               btn_raw,
  input  logic               done,
  output logic               start,
  output logic               busy,
  output logic               btn_clean,
  output logic               timeout,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  logic   wait_full;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rstb     (rstb),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean)
  );

`ifdef START_GEN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_q;
  logic            expire;
  logic            timeout_q;

  assign wait_full = (wait_q == TO_LAST);

  // A full wait only expires when the state's own exit is not taken this
  // cycle, so a done arriving on the last cycle still wins over the timeout.
  assign expire = wait_full &&
                  (((state_q == S_CLEAR) && done) || ((state_q == S_RUN) && !done));

  // Count cycles spent waiting for done; restart whenever a new run is fired.
  // The count holds at its last value if the CLEAR-to-RUN move lands on it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_q <= '0;
    end else if (state_q == S_FIRE) begin
      wait_q <= '0;
    end else if (((state_q == S_CLEAR) || (state_q == S_RUN)) &&
                 (state_d != S_RELEASE) && !wait_full) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  // Register the expiry so timeout is a clean one-cycle pulse aligned with
  // the entry into S_RELEASE.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign wait_full          = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
`endif

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fire once per press, ignore a stale done in S_CLEAR,
  // then wait for done (or expiry) and for the button to be released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_clean) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (!done) begin
          state_d = S_RUN;
        end else if (wait_full) begin
          state_d = S_RELEASE;
        end
      end
      S_RUN: begin
        if (done || wait_full) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!btn_clean) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign start = (state_q == S_FIRE);
  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// tb_start_pulse_gen: self-checking bench for start_pulse_gen with a
// behavioural reference model and a behavioural downstream done/F stage.
module tb_start_pulse_gen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int TO   = 8;

  // edge on which btn_clean rises for a button pressed before edge 1
  localparam int PRESS_LAT = SYNC + DEB;
  // edge on which the FSM enters S_CLEAR after such a press
  localparam int E_CLEAR   = PRESS_LAT + 2;

  localparam int P_IDLE    = 0;
  localparam int P_FIRE    = 1;
  localparam int P_CLEAR   = 2;
  localparam int P_RUN     = 3;
  localparam int P_RELEASE = 4;

`ifdef START_GEN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstb;
  logic       btn_raw;
  logic       done;
  logic       start;
  logic       busy;
  logic       btn_clean;
  logic       timeout;
  logic [2:0] state;
  logic [6:0] dut_vec;

  int tests_run    = 0;
  int tests_failed = 0;
  int starts_seen;

  // reference model state
  bit m_pipe[$];
  bit m_clean;
  int m_run;
  int m_phase;
  int m_wait;
  bit m_timeout;

  // downstream stage model
  bit ds_active;
  int ds_k;
  int ds_delay;
  int ds_stale;
  bit ds_never;
  bit ds_rand;

  start_pulse_gen #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .btn_raw  (btn_raw),
    .done     (done),
    .start    (start),
    .busy     (busy),
    .btn_clean(btn_clean),
    .timeout  (timeout),
    .state    (state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, start, busy, btn_clean, timeout};

  function automatic logic [6:0] exp_vec();
    logic [2:0] st;
    st = m_phase[2:0];
    return {st, (m_phase == P_FIRE), (m_phase != P_IDLE), m_clean, m_timeout};
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    m_clean   = 1'b0;
    m_run     = 0;
    m_phase   = P_IDLE;
    m_wait    = 0;
    m_timeout = 1'b0;
    ds_active = 1'b0;
    ds_k      = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled,
  // then update the downstream stage's done level.
  task automatic model_update();
    bit sync_now;
    bit clean_old;
    int ph_old;
    bit to_run;
    bit time_up;
    sync_now  = m_pipe[SYNC-1];
    clean_old = m_clean;
    ph_old    = m_phase;
    m_pipe.push_front(btn_raw);
    void'(m_pipe.pop_back());
    if (sync_now != m_clean) begin
      m_run++;
      if (m_run == DEB) begin
        m_clean = sync_now;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_timeout = 1'b0;
    case (ph_old)
      P_IDLE:    if (clean_old) m_phase = P_FIRE;
      P_FIRE:    begin m_phase = P_CLEAR; m_wait = 0; end
      P_CLEAR, P_RUN: begin
        to_run  = (ph_old == P_CLEAR) && !done;
        time_up = TO_EN && (m_wait + 1 >= TO);
        if ((ph_old == P_RUN) && done) begin
          m_phase = P_RELEASE;
        end else if (time_up && !to_run) begin
          m_phase   = P_RELEASE;
          m_timeout = 1'b1;
        end else begin
          if (to_run) m_phase = P_RUN;
          if (!time_up) m_wait++;
        end
      end
      P_RELEASE: if (!clean_old) m_phase = P_IDLE;
      default:   m_phase = P_IDLE;
    endcase
    if (ph_old == P_FIRE) begin
      ds_active = 1'b1;
      ds_k      = 0;
      if (ds_rand) begin
        ds_delay = $urandom_range(1, 12);
        ds_stale = $urandom_range(0, 3);
        ds_never = ($urandom_range(0, 7) == 0);
      end
    end else if (ds_active) begin
      ds_k++;
    end
    if (ds_active) begin
      if (ds_k < ds_stale)  done = 1'b1;
      else if (ds_never)    done = 1'b0;
      else                  done = (ds_k >= ds_delay);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic apply_reset();
    rstb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    btn_raw = 1'b1;
    done    = 1'b0;
    rstb    = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (dut_vec !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values got=%b exp=%b", dut_vec, 7'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (dut_vec !== 7'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", i, dut_vec, 7'd0);
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic test_clean_press();
    done = 1'b1; ds_delay = 10; ds_stale = 0; ds_never = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    starts_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (start) starts_seen++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL press_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i == PRESS_LAT - 1 || i == PRESS_LAT) begin
        tests_run++;
        if (btn_clean !== (i == PRESS_LAT)) begin
          tests_failed++;
          $display("[TB] FAIL press_clean_edge cyc=%0d got=%b exp=%b", i, btn_clean, (i == PRESS_LAT));
        end
      end
      if (i >= PRESS_LAT && i <= PRESS_LAT + 2) begin
        tests_run++;
        if ({start, busy} !== {(i == PRESS_LAT + 1), (i > PRESS_LAT)}) begin
          tests_failed++;
          $display("[TB] FAIL press_start_busy cyc=%0d got=%b%b exp=%b%b", i, start, busy,
                   (i == PRESS_LAT + 1), (i > PRESS_LAT));
        end
      end
      if (i == 25) btn_raw = 1'b0;
      if (i == 25 + PRESS_LAT || i == 26 + PRESS_LAT) begin
        tests_run++;
        if ({btn_clean, state} !== {1'b0, (i == 25 + PRESS_LAT) ? 3'd4 : 3'd0}) begin
          tests_failed++;
          $display("[TB] FAIL release_latency cyc=%0d got=%b/%0d", i, btn_clean, state);
        end
      end
    end
    tests_run++;
    if (starts_seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL press_start_count got=%0d exp=1", starts_seen);
    end
  endtask

  task automatic test_bounce();
    done = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    for (int i = 1; i <= 28; i++) begin
      btn_raw = (i <= 20) ? (((i - 1) / 2) % 2 == 0) : 1'b0;
      tick();
      tests_run++;
      if ({btn_clean, start} !== 2'b00 || dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL bounce cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stale_done();
    done = 1'b1; ds_delay = 6; ds_stale = 2; ds_never = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    starts_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (start) starts_seen++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL stale_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i >= E_CLEAR + 1 && i <= E_CLEAR + 3) begin
        tests_run++;
        if (state !== ((i == E_CLEAR + 3) ? 3'd3 : 3'd2)) begin
          tests_failed++;
          $display("[TB] FAIL stale_hold_clear cyc=%0d got=%0d exp=%0d", i, state,
                   (i == E_CLEAR + 3) ? 3 : 2);
        end
      end
    end
    tests_run++;
    if (starts_seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL stale_start_count got=%0d exp=1", starts_seen);
    end
  endtask

  task automatic test_repress_busy();
    done = 1'b1; ds_delay = 200; ds_stale = 0; ds_never = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    starts_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (start) starts_seen++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL repress_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i == 8)  btn_raw = 1'b0;
      if (i == 14) btn_raw = 1'b1;
    end
    tests_run++;
    if (starts_seen !== (TO_EN ? 2 : 1)) begin
      tests_failed++;
      $display("[TB] FAIL repress_start_count got=%0d exp=%0d", starts_seen, TO_EN ? 2 : 1);
    end
  endtask

  task automatic test_timeout();
    done = 1'b1; ds_delay = 0; ds_stale = 0; ds_never = 1'b1; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    for (int i = 1; i <= E_CLEAR + 110; i++) begin
      tick();
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL timeout_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i >= E_CLEAR + TO - 1 && i <= E_CLEAR + TO + 1) begin
        tests_run++;
        if ({timeout, state} !== {(TO_EN && i == E_CLEAR + TO),
                                  (TO_EN && i >= E_CLEAR + TO) ? 3'd4 : 3'd3}) begin
          tests_failed++;
          $display("[TB] FAIL timeout_edge cyc=%0d got=%b/%0d", i, timeout, state);
        end
      end
    end
    tests_run++;
    if ({timeout, state} !== {1'b0, TO_EN ? 3'd4 : 3'd3}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_final got=%b/%0d exp=0/%0d", timeout, state, TO_EN ? 4 : 3);
    end
  endtask

  task automatic test_simultaneous();
    done = 1'b1; ds_delay = TO - 1; ds_stale = 0; ds_never = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL simul_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i == E_CLEAR + TO - 1 || i == E_CLEAR + TO) begin
        tests_run++;
        if ({timeout, state} !== {1'b0, (i == E_CLEAR + TO) ? 3'd4 : 3'd3}) begin
          tests_failed++;
          $display("[TB] FAIL simul_done_wins cyc=%0d got=%b/%0d", i, timeout, state);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    done = 1'b1; ds_delay = 100; ds_stale = 0; ds_never = 1'b0; ds_rand = 1'b0;
    btn_raw = 1'b0;
    apply_reset();
    btn_raw = 1'b1;
    for (int i = 1; i <= E_CLEAR + 3; i++) tick();
    tests_run++;
    if (state !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL midrun_in_run got=%0d exp=3", state);
    end
    #2;
    rstb = 1'b0;
    #1;
    tests_run++;
    if (dut_vec !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_async_reset got=%b exp=%b", dut_vec, 7'd0);
    end
    model_reset();
    done = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    starts_seen = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (start) starts_seen++;
      tests_run++;
      if (dut_vec !== exp_vec() || start !== (i == PRESS_LAT + 1)) begin
        tests_failed++;
        $display("[TB] FAIL midrun_restart cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    tests_run++;
    if (starts_seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL midrun_start_count got=%0d exp=1", starts_seen);
    end
  endtask

  task automatic test_random();
    int hold;
    done = 1'b1; ds_delay = 5; ds_stale = 1; ds_never = 1'b0; ds_rand = 1'b1;
    btn_raw = 1'b0;
    apply_reset();
    hold = 0;
    for (int i = 1; i <= 500; i++) begin
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
      end
      hold--;
      tick();
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_stale_done();
    test_repress_busy();
    test_timeout();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
